// File: rtl/ternary_pkg.sv
// Shared types and constants for the trit-serial ternary ALU.
// A trit is packed {hi,lo}: 00=0, 01=1, 10=2, 11=invalid.
package ternary_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_0   = 2'b00;
    localparam trit_t TRIT_1   = 2'b01;
    localparam trit_t TRIT_2   = 2'b10;
    localparam trit_t TRIT_BAD = 2'b11;

    typedef enum logic [1:0] {
        OP_MIN  = 2'b00,
        OP_MAX  = 2'b01,
        OP_ANY  = 2'b10,
        OP_CONS = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic logic trit_is_bad(input trit_t t);
        return (t == TRIT_BAD);
    endfunction

endpackage

// File: rtl/ternary_trit_op.sv
// Single combinational ternary gate cell shared across all trit positions.
// An invalid code on either input forces the neutral value 1 and flags it.
module ternary_trit_op
    import ternary_pkg::*;
(
    input  op_t   op,
    input  trit_t x,
    input  trit_t y,
    output trit_t z,
    output logic  bad
);

    logic [2:0] sum_s;

    // Evaluate the selected ternary function on one trit pair
    always_comb begin
        bad   = trit_is_bad(x) | trit_is_bad(y);
        sum_s = {1'b0, x} + {1'b0, y};
        z     = TRIT_1;
        if (bad) begin
            z = TRIT_1;
        end else begin
            case (op)
                OP_MIN:  z = (x < y) ? x : y;
                OP_MAX:  z = (x > y) ? x : y;
                // any = clamp(x + y - 1, 0, 2)
                OP_ANY: begin
                    case (sum_s)
                        3'd0, 3'd1: z = TRIT_0;
                        3'd2:       z = TRIT_1;
                        default:    z = TRIT_2;
                    endcase
                end
                OP_CONS: z = (x == y) ? x : TRIT_1;
                default: z = TRIT_1;
            endcase
        end
    end

endmodule

// File: rtl/ternary_serial_alu.sv
// Trit-serial word processor: captures an operand pair, runs one trit per clock
// through a shared gate cell (LS trit first) and holds the result until taken.
module ternary_serial_alu
    import ternary_pkg::*;
#(
    parameter int TRITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [2*TRITS-1:0]   a,
    input  logic [2*TRITS-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*TRITS-1:0]   result,
    output logic                 err
);

    localparam int               CNT_W    = $clog2(TRITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRITS - 1);

    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [2*TRITS-1:0]   a_r;
    logic [2*TRITS-1:0]   b_r;
    op_t                  op_r;
    logic [2*TRITS-1:0]   result_r;
    logic                 err_r;
    logic                 in_ready_r;
    logic                 out_valid_r;

    logic [2*TRITS-1:0]   a_shift_s;
    logic [2*TRITS-1:0]   b_shift_s;
    trit_t                trit_a_s;
    trit_t                trit_b_s;
    trit_t                trit_res_s;
    logic                 trit_bad_s;

    // Select the current trit of each captured operand
    always_comb begin
        a_shift_s = a_r >> {cnt_r, 1'b0};
        b_shift_s = b_r >> {cnt_r, 1'b0};
        trit_a_s  = a_shift_s[1:0];
        trit_b_s  = b_shift_s[1:0];
    end

    ternary_trit_op u_cell (
        .op  (op_r),
        .x   (trit_a_s),
        .y   (trit_b_s),
        .z   (trit_res_s),
        .bad (trit_bad_s)
    );

    // Next-state logic for the sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) state_next_s = S_RUN;
                else          state_next_s = S_IDLE;
            end
            S_RUN: begin
                if (cnt_r == CNT_LAST) state_next_s = S_DONE;
                else                   state_next_s = S_RUN;
            end
            S_DONE: begin
                if (out_ready) state_next_s = S_IDLE;
                else           state_next_s = S_DONE;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register with registered handshake flags derived from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == S_IDLE);
            out_valid_r <= (state_next_s == S_DONE);
        end
    end

    // Operand capture, trit counter and result/err accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= '0;
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= OP_MIN;
            result_r <= '0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        op_r     <= op_t'(op);
                        result_r <= '0;
                        err_r    <= 1'b0;
                        cnt_r    <= '0;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < TRITS; i++) begin
                        if (cnt_r == CNT_W'(i)) result_r[2*i +: 2] <= trit_res_s;
                    end
                    err_r <= err_r | trit_bad_s;
                    // Saturate at the last trit so the index never leaves range
                    if (cnt_r != CNT_LAST) cnt_r <= cnt_r + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign err       = err_r;

endmodule
